// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Single-port arbiter for the external 16-bit asynchronous SRAM. Two streams
// share the device: the capture write stream and the line-buffer fill read
// stream. The arbiter owns every SRAM pin and the tristate data bus. It grants
// at most one access per cycle. Writes win, but a pending read is starved for
// at most WR_BURST_MAX consecutive write grants.
//
// Handshake: a requester raises *_req with its address/data stable and holds
// them until the matching *_ack. The ack is combinational and is high for
// exactly the cycle in which the access is granted. Dropping a request before
// its ack is legal; that request is simply not serviced.
//
// Ports
//   cmos_pclk  in     sole clock, rising edge
//   rst        in     synchronous active-high reset
//   wr_req     in     write request
//   wr_addr    in     write word address
//   wr_data    in     write data
//   wr_ack     out    write granted this cycle (combinational)
//   rd_req     in     read request
//   rd_addr    in     read word address
//   rd_ack     out    read granted this cycle (combinational)
//   rd_data    out    registered read data
//   rd_valid   out    one-cycle strobe, rd_data valid (grant + 2 cycles)
//   sram_data  inout  SRAM data bus, driven only while a write is on the pins
//   sram_addr  out    registered SRAM address
//   sram_we    out    active-low write enable, registered
//   sram_oe    out    active-low output enable, registered
//   sram_cs    out    chip select, tied active (0)
//   sram_byte  out    byte lane enables, tied active (00)
//
// Compile option
//   SRAM_ARB_TURNAROUND_EN : when defined, a change of direction between
//   WRITE and READ inserts one dead cycle (state TURN) with the bus released.
// ---------------------------------------------------------------------------
module sram_arbiter #(
   parameter int ADDR_W       = 18,
   parameter int DATA_W       = 16,
   parameter int WR_BURST_MAX = 8
) (
   input  logic              cmos_pclk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_we,
   output logic              sram_oe,
   output logic              sram_cs,
   output logic [1:0]        sram_byte
);

   // State names the direction of the access currently on the SRAM pins.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      TURN  = 2'd3
   } state_t;

   localparam logic [7:0] RUN_MAX = 8'(WR_BURST_MAX);

   state_t            state, state_next;
   logic [7:0]        wr_run, wr_run_next;
   logic [DATA_W-1:0] data_q;
   logic              pick_wr, pick_rd, withhold;

   // Priority choice, before any turnaround hold-off.
   always_comb begin
      pick_wr = 1'b0;
      pick_rd = 1'b0;
      if (wr_req && !(rd_req && (wr_run == RUN_MAX)))
         pick_wr = 1'b1;
      else if (rd_req)
         pick_rd = 1'b1;
   end

`ifdef SRAM_ARB_TURNAROUND_EN
   // Hold off a grant that reverses the direction currently on the pins.
   // From IDLE or TURN there is nothing to turn around.
   assign withhold = (pick_wr && (state == READ)) || (pick_rd && (state == WRITE));
`else
   assign withhold = 1'b0;
`endif

   // Acks are masked during reset so nothing is granted while rst is high.
   assign wr_ack = pick_wr && !withhold && !rst;
   assign rd_ack = pick_rd && !withhold && !rst;

   always_comb begin
      state_next  = IDLE;
      wr_run_next = wr_run;
      if (wr_ack)
         state_next = WRITE;
      else if (rd_ack)
         state_next = READ;
      else if (withhold)
         state_next = TURN;

      // wr_run counts writes that overtook a waiting read. A withheld
      // (TURN) cycle leaves it untouched.
      if (rd_ack)
         wr_run_next = 8'd0;
      else if (wr_ack) begin
         if (!rd_req)
            wr_run_next = 8'd0;
         else if (wr_run < RUN_MAX)
            wr_run_next = wr_run + 8'd1;
      end
   end

   always_ff @(posedge cmos_pclk) begin
      if (rst) begin
         state     <= IDLE;
         wr_run    <= 8'd0;
         data_q    <= '0;
         sram_addr <= '0;
         sram_we   <= 1'b1;
         sram_oe   <= 1'b1;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
      end else begin
         state    <= state_next;
         wr_run   <= wr_run_next;
         sram_we  <= !wr_ack;
         sram_oe  <= !rd_ack;
         if (wr_ack) begin
            sram_addr <= wr_addr;
            data_q    <= wr_data;
         end else if (rd_ack) begin
            sram_addr <= rd_addr;
         end
         // The read is on the pins for the whole READ cycle; capture the bus
         // at its end so rd_valid lands two cycles after the grant.
         rd_valid <= (state == READ);
         if (state == READ)
            rd_data <= sram_data;
      end
   end

   assign sram_data = (state == WRITE) ? data_q : {DATA_W{1'bz}};
   assign sram_cs   = 1'b0;
   assign sram_byte = 2'b00;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter with a behavioural asynchronous SRAM on
// the shared bus. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge. Expected values are hand-computed
// constants; the grant pattern under contention is held in exp_q.
// Define SRAM_ARB_TURNAROUND_EN for both files to exercise the dead cycle.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

   localparam int ADDR_W       = 18;
   localparam int DATA_W       = 16;
   localparam int WR_BURST_MAX = 8;

   // ---------------- clock / reset / DUT ----------------
   logic              cmos_pclk = 1'b0;
   logic              rst;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   wire  [DATA_W-1:0] sram_data;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_we;
   logic              sram_oe;
   logic              sram_cs;
   logic [1:0]        sram_byte;

   always #5 cmos_pclk = ~cmos_pclk;

   sram_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .WR_BURST_MAX (WR_BURST_MAX)
   ) dut (
      .cmos_pclk (cmos_pclk),
      .rst       (rst),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_ack    (rd_ack),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .sram_data (sram_data),
      .sram_addr (sram_addr),
      .sram_we   (sram_we),
      .sram_oe   (sram_oe),
      .sram_cs   (sram_cs),
      .sram_byte (sram_byte)
   );

   // ---------------- SRAM model ----------------
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   assign sram_data = (!sram_cs && !sram_oe && sram_we) ? mem[sram_addr] : {DATA_W{1'bz}};

   always @(posedge cmos_pclk)
      if (!sram_cs && !sram_we)
         mem[sram_addr] <= sram_data;

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_errors = 0;
   logic [1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge cmos_pclk);
      #1;
   endtask

   task automatic mid();
      @(negedge cmos_pclk);
   endtask

   task automatic check_bus_z(input string tag);
      check(tag, {16'h0, sram_data}, {16'h0, 16'hzzzz});
   endtask

   // Single read from IDLE: ack in C, oe low in C+1, data in C+2.
   task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
      next_cycle();
      rd_req  = 1'b1;
      rd_addr = a;
      mid();
      check("rd_ack_c", rd_ack, 1);
      check("wr_ack_c", wr_ack, 0);
      next_cycle();
      rd_req = 1'b0;
      mid();
      check("oe_c1", sram_oe, 0);
      check("we_c1", sram_we, 1);
      check("addr_c1", 32'(sram_addr), 32'(a));
      check("rd_valid_c1", rd_valid, 0);
      next_cycle();
      mid();
      check("rd_valid_c2", rd_valid, 1);
      check("rd_data_c2", 32'(rd_data), 32'(exp));
      check("oe_c2", sram_oe, 1);
      next_cycle();
      mid();
      check("rd_valid_c3", rd_valid, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0] e, prev;

      rst     = 1'b1;
      wr_req  = 1'b1;
      rd_req  = 1'b1;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      mem[18'h3FFFF] = 16'h1234;

      // Reset with both requests high: nothing may be granted.
      for (int i = 0; i < 3; i++) begin
         mid();
         check("rst_wr_ack", wr_ack, 0);
         check("rst_rd_ack", rd_ack, 0);
         check("rst_we", sram_we, 1);
         check("rst_oe", sram_oe, 1);
         check("rst_rd_valid", rd_valid, 0);
         check("rst_addr", 32'(sram_addr), 0);
         check("rst_cs_byte", {sram_cs, sram_byte}, 0);
         check_bus_z("rst_bus");
         next_cycle();
      end
      rst    = 1'b0;
      wr_req = 1'b0;
      rd_req = 1'b0;
      mid();
      check("idle_wr_ack", wr_ack, 0);
      check("idle_rd_ack", rd_ack, 0);

      // Write stream, back-to-back grants.
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         wr_req  = 1'b1;
         wr_addr = ADDR_W'(18'h10 + i);
         wr_data = DATA_W'(16'hA5A0 + i);
         mid();
         check("ws_wr_ack", wr_ack, 1);
         check("ws_rd_ack", rd_ack, 0);
         if (i > 0) begin
            check("ws_we", sram_we, 0);
            check("ws_addr", 32'(sram_addr), 32'(18'h10 + i - 1));
            check("ws_data", 32'(sram_data), 32'(16'hA5A0 + i - 1));
         end
      end
      next_cycle();
      wr_req = 1'b0;
      mid();
      check("ws_last_ack", wr_ack, 0);
      check("ws_last_we", sram_we, 0);
      check("ws_last_addr", 32'(sram_addr), 32'h13);
      check("ws_last_data", 32'(sram_data), 32'hA5A3);
      next_cycle();
      mid();
      check("ws_end_we", sram_we, 1);
      check_bus_z("ws_end_bus");

      // Read latency and read-back of written data.
      do_read(18'h3FFFF, 16'h1234);
      do_read(18'h00012, 16'hA5A2);
      do_read(18'h00010, 16'hA5A0);

      // Contention: both requests held continuously.
      for (int k = 0; k < 22; k++) begin
`ifdef SRAM_ARB_TURNAROUND_EN
         if ((k % 11) < 8)       exp_q.push_back(2'b10);
         else if ((k % 11) == 9) exp_q.push_back(2'b01);
         else                    exp_q.push_back(2'b00);
`else
         if ((k % 9) < 8) exp_q.push_back(2'b10);
         else             exp_q.push_back(2'b01);
`endif
      end
      next_cycle();
      wr_req  = 1'b1;
      rd_req  = 1'b1;
      wr_addr = 18'h00100;
      wr_data = 16'h5A5A;
      rd_addr = 18'h3FFFF;
      prev    = 2'b00;
      while (exp_q.size() > 0) begin
         mid();
         e = exp_q.pop_front();
         check("grant", {wr_ack, rd_ack}, e);
         // Pins show the previous cycle's grant; a gap must release the bus.
         check("pins", {~sram_we, ~sram_oe}, prev);
         if (prev == 2'b00)
            check_bus_z("gap_bus");
         prev = e;
         next_cycle();
      end
      wr_req = 1'b0;
      rd_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mid();
         next_cycle();
      end

      // Reset during the pin cycle of a read.
      rd_req  = 1'b1;
      rd_addr = 18'h3FFFF;
      mid();
      check("rr_rd_ack", rd_ack, 1);
      next_cycle();
      rd_req = 1'b0;
      rst    = 1'b1;
      mid();
      check("rr_oe_inflight", sram_oe, 0);
      check("rr_ack_in_rst", {wr_ack, rd_ack}, 0);
      next_cycle();
      rst = 1'b0;
      mid();
      check("rr_rd_valid", rd_valid, 0);
      check("rr_rd_data", 32'(rd_data), 0);
      check("rr_oe", sram_oe, 1);
      check("rr_we", sram_we, 1);
      check("rr_addr", 32'(sram_addr), 0);
      check_bus_z("rr_bus");
      next_cycle();
      mid();
      check("rr_rd_valid_late", rd_valid, 0);

      // Reset during the pin cycle of a write.
      next_cycle();
      wr_req  = 1'b1;
      wr_addr = 18'h00020;
      wr_data = 16'hBEEF;
      mid();
      check("rw_wr_ack", wr_ack, 1);
      next_cycle();
      wr_req = 1'b0;
      rst    = 1'b1;
      mid();
      check("rw_we_inflight", sram_we, 0);
      next_cycle();
      rst = 1'b0;
      mid();
      check("rw_we", sram_we, 1);
      check_bus_z("rw_bus");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
